frame_scanout: RTL and testbench

// - Display-side reader of the 2-bit-per-pixel frame buffer that the renderer fills (colour code + 19-bit write address).
// - Regenerates the renderer's address per display pixel, reads the buffer and maps the code through a palette to 24-bit RGB.
// - Delays sync/active to match the read pipeline, for the HDMI/TMDS path.
// - Owns double-buffer bank selection, so the renderer always writes the bank not being shown.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_delay_line.sv | 21 ++
 rtl/frame_scanout.sv | 108 ++++++++++
 tb/tb_frame_scanout.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer address and colour-code definitions shared by the renderer and scanout.
package fb_pkg;
  localparam int FB_ADDR_W = 19;
  localparam int FB_STRIDE = 640;
  localparam logic [23:0] COLOR_MOVABLE = 24'h77_77_77;
  localparam logic [23:0] COLOR_STATIC  = 24'h11_11_11;
  localparam logic [23:0] COLOR_BG      = 24'hFF_FF_FF;
  typedef enum logic [1:0] {
    CODE_NONE    = 2'b00,
    CODE_MOVABLE = 2'b01,
    CODE_STATIC  = 2'b10,
    CODE_BG      = 2'b11
  } color_code_t;
  typedef enum logic {
    SHOWING = 1'b0,
    PENDING = 1'b1
  } bank_state_t;
  // The buffer is stored at half resolution: one word per 2x2 display pixels.
  function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic [10:0] h, input logic [9:0] v,
                                                        input int stride);
    return FB_ADDR_W'(h[10:1]) + FB_ADDR_W'(stride) * FB_ADDR_W'(v[9:1]);
  endfunction
endpackage

// File: rtl/fb_delay_line.sv
// fb_delay_line: reset-clearable shift register of DEPTH stages, WIDTH bits each.
module fb_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end
  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: reads the 2bpp frame buffer per display pixel, maps codes to RGB,
// aligns sync/active to the read pipeline and owns double-buffer bank selection.
module frame_scanout
  import fb_pkg::*;
#(
  parameter int          FB_STRIDE     = fb_pkg::FB_STRIDE,
  parameter int          RD_LATENCY    = 2,
  parameter logic [23:0] COLOR_MOVABLE = fb_pkg::COLOR_MOVABLE,
  parameter logic [23:0] COLOR_STATIC  = fb_pkg::COLOR_STATIC,
  parameter logic [23:0] COLOR_BG      = fb_pkg::COLOR_BG
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  input  logic        render_done_in,
  output logic [19:0] rd_addr_out,
  output logic        rd_en_out,
  input  logic [1:0]  rd_data_in,
  output logic        wr_bank_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic [7:0]  dropped_out
);
  bank_state_t state_q, state_d;
  logic        show_bank_q, show_bank_d;
  logic [7:0]  dropped_q, dropped_d;
  logic        swap, drop;
  logic [19:0] rd_addr_q, rd_addr_d;
  logic        rd_en_q;
  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  sync_q, sync_dly;
  color_code_t code;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= SHOWING;
      show_bank_q <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      show_bank_q <= show_bank_d;
      dropped_q   <= dropped_d;
    end
  end

  // A frame finishing while one is already waiting displaces it; a same-cycle new_frame wins.
  always_comb begin
    swap    = new_frame_in && (render_done_in || state_q == PENDING);
    drop    = state_q == PENDING && render_done_in && !new_frame_in;
    state_d = new_frame_in ? SHOWING : render_done_in ? PENDING : state_q;
  end

  always_comb begin
    show_bank_d = show_bank_q ^ swap;
    dropped_d   = (drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    wr_bank_out = ~show_bank_q;
  end

  assign dropped_out = dropped_q;

  // {hsync, vsync, active} delayed to line up with rd_data_in; one more stage below.
  fb_delay_line #(
    .WIDTH(3),
    .DEPTH(RD_LATENCY + 1)
  ) u_sync_dly (
    .clk_i  (clk_in),
    .rst_n_i(rst_n_in),
    .d_i    ({hsync_in, vsync_in, active_draw_in}),
    .q_o    (sync_dly)
  );

  always_comb begin
    rd_addr_d = {show_bank_q, fb_word_addr(hcount_in, vcount_in, FB_STRIDE)};
    code      = color_code_t'(rd_data_in);
    rgb_d     = !sync_dly[0]          ? 24'h0 :
                code == CODE_MOVABLE  ? COLOR_MOVABLE :
                code == CODE_STATIC   ? COLOR_STATIC :
                code == CODE_BG       ? COLOR_BG : 24'h0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rgb_q     <= '0;
      sync_q    <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= active_draw_in;
      rgb_q     <= rgb_d;
      sync_q    <= sync_dly;
    end
  end

  assign rd_addr_out                          = rd_addr_q;
  assign rd_en_out                            = rd_en_q;
  assign {red_out, green_out, blue_out}       = rgb_q;
  assign {hsync_out, vsync_out, active_out}   = sync_q;
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: table-driven pixel vectors plus bank/drop/reset sequences,
// with a scoreboard queue for the RD_LATENCY+2 output pipeline.
module tb_frame_scanout;
  localparam int LAT = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, active_draw_in = 1'b0;
  logic        new_frame_in = 1'b0, render_done_in = 1'b0;
  logic [19:0] rd_addr_out;
  logic        rd_en_out;
  logic [1:0]  rd_data_in = 2'b00;
  logic        wr_bank_out;
  logic [7:0]  red_out, green_out, blue_out;
  logic        hsync_out, vsync_out, active_out;
  logic [7:0]  dropped_out;

  always #5 clk_in = ~clk_in;

  frame_scanout dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .active_draw_in(active_draw_in),
    .new_frame_in  (new_frame_in),
    .render_done_in(render_done_in),
    .rd_addr_out   (rd_addr_out),
    .rd_en_out     (rd_en_out),
    .rd_data_in    (rd_data_in),
    .wr_bank_out   (wr_bank_out),
    .red_out       (red_out),
    .green_out     (green_out),
    .blue_out      (blue_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .active_out    (active_out),
    .dropped_out   (dropped_out)
  );

  function automatic logic [1:0] mem_code(input logic [19:0] a);
    return a[1:0] ^ a[5:4] ^ a[11:10] ^ a[19:18] ^ 2'b10;
  endfunction

  function automatic logic [23:0] pal(input logic [1:0] c);
    case (c)
      2'b01:   return 24'h777777;
      2'b10:   return 24'h111111;
      2'b11:   return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // Two-stage synchronous BRAM: data valid two cycles after the address.
  logic [19:0] bram_a = '0;
  always @(posedge clk_in) begin
    bram_a     <= rd_addr_out;
    rd_data_in <= mem_code(bram_a);
  end

  typedef struct {
    logic [23:0] rgb;
    logic        hs, vs, act;
  } exp_t;
  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, act;
    logic [18:0] waddr;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[12];
  int          n_vec = 0, n_err = 0;
  logic        bank_m, pend_m;
  int          drop_m;
  logic [19:0] prev_addr;
  logic        prev_en;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  task automatic model_reset();
    bank_m    = 1'b0;
    pend_m    = 1'b0;
    drop_m    = 0;
    prev_addr = '0;
    prev_en   = 1'b0;
    sbq.delete();
    repeat (LAT) sbq.push_back('{rgb: 24'h0, hs: 1'b0, vs: 1'b0, act: 1'b0});
  endtask

  // Called at a negedge: check what the last posedge produced, then drive the next pixel.
  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic hs, input logic vs,
                      input logic act, input logic rd, input logic nf, input logic [18:0] wa);
    exp_t e;
    logic nb;
    if (sbq.size() >= LAT) begin
      e = sbq.pop_front();
      chk("rgb", {red_out, green_out, blue_out}, e.rgb);
      chk("hsync_out", hsync_out, e.hs);
      chk("vsync_out", vsync_out, e.vs);
      chk("active_out", active_out, e.act);
    end
    nb = ~bank_m;
    chk("rd_addr", rd_addr_out, prev_addr);
    chk("rd_en", rd_en_out, prev_en);
    chk("wr_bank", wr_bank_out, nb);
    chk("dropped", dropped_out, drop_m[7:0]);
    hcount_in      = h;
    vcount_in      = v;
    hsync_in       = hs;
    vsync_in       = vs;
    active_draw_in = act;
    render_done_in = rd;
    new_frame_in   = nf;
    prev_addr      = {bank_m, wa};
    prev_en        = act;
    sbq.push_back('{rgb: act ? pal(mem_code({bank_m, wa})) : 24'h0, hs: hs, vs: vs, act: act});
    if (nf) begin
      if (pend_m || rd) bank_m = ~bank_m;
      pend_m = 1'b0;
    end else if (rd) begin
      if (pend_m && drop_m < 255) drop_m++;
      pend_m = 1'b1;
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{h: 11'd0,    v: 10'd0,    hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd0};
    vecs[1]  = '{h: 11'd1,    v: 10'd0,    hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd0};
    vecs[2]  = '{h: 11'd2,    v: 10'd1,    hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd1};
    vecs[3]  = '{h: 11'd639,  v: 10'd479,  hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd153279};
    vecs[4]  = '{h: 11'd100,  v: 10'd2,    hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd690};
    vecs[5]  = '{h: 11'd101,  v: 10'd3,    hs: 1'b1, vs: 1'b0, act: 1'b0, waddr: 19'd690};
    vecs[6]  = '{h: 11'd800,  v: 10'd500,  hs: 1'b0, vs: 1'b1, act: 1'b0, waddr: 19'd160400};
    vecs[7]  = '{h: 11'd2047, v: 10'd1023, hs: 1'b1, vs: 1'b1, act: 1'b0, waddr: 19'd328063};
    vecs[8]  = '{h: 11'd5,    v: 10'd7,    hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd1922};
    vecs[9]  = '{h: 11'd638,  v: 10'd478,  hs: 1'b0, vs: 1'b0, act: 1'b1, waddr: 19'd153279};
    vecs[10] = '{h: 11'd0,    v: 10'd2,    hs: 1'b0, vs: 1'b1, act: 1'b1, waddr: 19'd640};
    vecs[11] = '{h: 11'd33,   v: 10'd10,   hs: 1'b1, vs: 1'b0, act: 1'b1, waddr: 19'd3216};

    model_reset();
    repeat (3) @(negedge clk_in);
    chk("reset_rd_addr", rd_addr_out, 20'h0);
    chk("reset_rd_en", rd_en_out, 1'b0);
    chk("reset_rgb", {red_out, green_out, blue_out}, 24'h0);
    chk("reset_sync", {hsync_out, vsync_out, active_out}, 3'b000);
    chk("reset_wr_bank", wr_bank_out, 1'b1);
    chk("reset_dropped", dropped_out, 8'd0);
    rst_n_in = 1'b1;

    foreach (vecs[i]) step(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].act, 1'b0, 1'b0, vecs[i].waddr);
    idle(2);
    step(11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0);
    idle(LAT + 1);

    // render_done mid-frame, then new_frame: swap on the following cycle
    step(11'd10, 10'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd1285);
    step(11'd12, 10'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd1286);
    chk("pending_no_swap", wr_bank_out, 1'b1);
    step(11'd14, 10'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 19'd1287);
    chk("swap_wr_bank", wr_bank_out, 1'b0);
    chk("swap_no_drop", dropped_out, 8'd0);
    for (int i = 0; i < 6; i++) step(11'(2 * i), 10'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'(1920 + i));

    // two completions in one frame drop one
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0);
    idle(1);
    chk("one_drop", dropped_out, 8'd1);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd0);
    chk("same_cycle_swap_showing", wr_bank_out, 1'b0);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd0);
    chk("same_cycle_swap_pending", wr_bank_out, 1'b1);
    chk("same_cycle_no_drop", dropped_out, 8'd1);

    for (int i = 0; i < 300; i++) step(11'(2 * i), 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'(i));
    idle(1);
    chk("drop_saturate", dropped_out, 8'd255);
    step(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0);
    for (int i = 0; i < 5; i++) step(11'(40 + 2 * i), 10'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19'(6420 + i));

    // asynchronous reset mid-line
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_rd_addr", rd_addr_out, 20'h0);
    chk("async_rd_en", rd_en_out, 1'b0);
    chk("async_rgb", {red_out, green_out, blue_out}, 24'h0);
    chk("async_sync", {hsync_out, vsync_out, active_out}, 3'b000);
    chk("async_wr_bank", wr_bank_out, 1'b1);
    chk("async_dropped", dropped_out, 8'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(11'(200 + 2 * i), 10'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'(2660 + i));
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
